rv32i_main_fsm: RTL
===================

// Module: rv32i_main_fsm
// PURPOSE
//  Main control FSM for the multicycle RV32I core: sequences PC, memory, IR, register file and ALU muxes.
//  Moore FSM plus combinational ALU decode; sits beside the datapath inside the multicycle core.
//  Inputs are the IR opcode fields and comparison flags; outputs are every datapath enable and mux select.
// PARAMETERS
//  none (encodings are fixed in rv32i_ctrl_pkg)
// PORTS
//  clk          in   1   core clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  ena          in   1   stall when low: state holds, all write enables forced 0
//  op           in   7   instr[6:0] from IR
//  funct3       in   3   instr[14:12]
//  funct7_5     in   1   instr[30]
//  cmp_eq       in   1   rs1==rs2 (ALU equal flag, valid in BRANCH)
//  cmp_lt       in   1   signed rs1<rs2 (valid in BRANCH)
//  cmp_ltu      in   1   unsigned rs1<rs2 (valid in BRANCH)
//  pc_write     out  1   load PC (and old-PC register) this cycle
//  adr_src      out  1   0=PC, 1=result
//  mem_write    out  1   memory write strobe
//  ir_write     out  1   latch instruction register
//  reg_write    out  1   register file write
//  alu_src_a    out  2   00=PC, 01=OLD_PC, 10=REG_A, 11=ZERO
//  alu_src_b    out  2   00=REG_B, 01=IMM, 10=FOUR
//  res_src      out  2   00=ALU_OUT, 01=DATA, 10=ALU_RESULT
//  imm_src      out  3   000=I, 001=S, 010=B, 011=J, 100=U
//  alu_control  out  alu_control_t   ALU operation
//  state        out  4   current state_t (debug/verification)
// BEHAVIOUR
//  Reset: state=FETCH at next posedge with rst=1. During rst, pc_write/ir_write/reg_write/mem_write=0.
//  Mid-instruction rst aborts the instruction, no partial write.
//  Outputs are combinational from state (plus op/funct for imm_src, alu_control, branch pc_write).
//  Every enable is ANDed with ena&~rst. State advances only when ena=1.
//  Defaults in all states: all enables 0, selects 0, alu_op ADD.
//  FETCH:    adr_src=0, ir_write, a=PC, b=FOUR, ADD, res=ALU_RESULT, pc_write -> DECODE
//  DECODE:   a=OLD_PC, b=IMM(B), ADD (branch target into ALU_OUT); next state by op:
//            0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH,
//            1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC, other->ILLEGAL path
//  MEMADR:   a=REG_A, b=IMM, ADD; ->MEMREAD (op[5]=0) or MEMWRITE (op[5]=1)
//  MEMREAD:  adr_src=1, res=ALU_OUT ->MEMWB
//  MEMWB:    res=DATA, reg_write ->FETCH
//  MEMWRITE: adr_src=1, res=ALU_OUT, mem_write ->FETCH
//  EXEC_R:   a=REG_A, b=REG_B, alu_op=FUNCT ->ALUWB;   EXEC_I: a=REG_A, b=IMM, FUNCT ->ALUWB
//  ALUWB:    res=ALU_OUT, reg_write ->FETCH
//  BRANCH:   a=REG_A, b=REG_B, SUB, res=ALU_OUT; pc_write=taken
//            taken: f3 000 eq, 001 ~eq, 100 lt, 101 ~lt, 110 ltu, 111 ~ltu; else 0 ->FETCH
//  JAL:      a=OLD_PC, b=FOUR, res=ALU_OUT (target), pc_write ->ALUWB (rd=old PC+4)
//  JALR:     a=REG_A, b=IMM, ADD, res=ALU_RESULT, pc_write ->JALWB
//  JALWB:    a=OLD_PC, b=FOUR, res=ALU_RESULT, reg_write ->FETCH
//  LUI:      a=ZERO, b=IMM(U) ->ALUWB;   AUIPC: a=OLD_PC, b=IMM(U) ->ALUWB
//  ALU decode: FUNCT uses funct3 + (op[5]&funct7_5 sub / funct7_5 sra):
//            ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND
//  Latency: R/I/LUI/AUIPC/JAL 4 cycles, load 5, store 4, branch 3, JALR 4.
// CONFIGURATION
//  RV32I_FSM_ILLEGAL_TRAP_EN defined:
//            unknown op -> ILLEGAL state, absorbing until rst, all enables 0; extra output illegal_op=1 there.
//  Undefined: unknown op in DECODE -> FETCH (executes as NOP, PC already +4); no illegal_op port.
// STRUCTURE
//  Package rv32i_ctrl_pkg: state_t enum, alu_src_a_t/alu_src_b_t/res_src_t/imm_src_t/alu_op_t enums,
//  opcode localparams; alu_control_t stays in alu_types.sv.
//  Sub-module rv32i_alu_decoder: combinational (alu_op, funct3, funct7_5, op5) -> alu_control.
//  Top holds state register, next-state logic, output decode, branch-taken logic.
// TESTING
//  rst=1 2 cycles, op=0110011 -> state=FETCH; no enables during rst; FETCH, DECODE, EXEC_R, ALUWB, FETCH with
//   reg_write only in ALUWB.
//  op=0000011 -> 5-cycle sequence; MEMREAD adr_src=1; MEMWB res_src=01, reg_write=1.
//  op=1100011 f3=001, cmp_eq=0 -> pc_write=1 in BRANCH; repeat cmp_eq=1 -> pc_write=0; f3=110 cmp_ltu=1 -> taken.
//  ena=0 held 3 cycles in EXEC_I -> state unchanged, all enables 0; ena=1 -> ALUWB.
//  rst asserted in MEMWRITE -> mem_write=0 that cycle, state=FETCH next.
//  op=1111111: without macro DECODE->FETCH; with RV32I_FSM_ILLEGAL_TRAP_EN -> ILLEGAL, illegal_op=1 held.

Source files
------------

// File: rtl/alu_types.sv
// alu_types_pkg: ALU operation encoding shared by the control path and the ALU.
package alu_types_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_control_t;
endpackage

// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: state, mux-select and opcode encodings for the multicycle RV32I control FSM.
package rv32i_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB, S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;
  typedef enum logic [1:0] {A_PC, A_OLD_PC, A_REG_A, A_ZERO} alu_src_a_t;
  typedef enum logic [1:0] {B_REG_B, B_IMM, B_FOUR} alu_src_b_t;
  typedef enum logic [1:0] {R_ALU_OUT, R_DATA, R_ALU_RESULT} res_src_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  // funct3 bit 0 inverts the condition; 010/011 are not branch encodings
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt,
                                        input logic ltu);
    return (f3[2:1] == 2'b01) ? 1'b0 : ((f3[2] ? (f3[1] ? ltu : lt) : eq) ^ f3[0]);
  endfunction
endpackage

// File: rtl/rv32i_alu_decoder.sv
// rv32i_alu_decoder: maps the FSM's ALU request plus funct fields to an ALU operation.
module rv32i_alu_decoder
  import rv32i_ctrl_pkg::*;
  import alu_types_pkg::*;
(
  input  alu_op_t      alu_op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic         op5,
  output alu_control_t alu_control
);
  alu_control_t funct_ctl;
  always_comb begin
    funct_ctl = ALU_ADD;
    case (funct3)
      3'b000: funct_ctl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: funct_ctl = ALU_SLL;
      3'b010: funct_ctl = ALU_SLT;
      3'b011: funct_ctl = ALU_SLTU;
      3'b100: funct_ctl = ALU_XOR;
      3'b101: funct_ctl = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: funct_ctl = ALU_OR;
      3'b111: funct_ctl = ALU_AND;
      default: funct_ctl = ALU_ADD;
    endcase
    alu_control = (alu_op == ALUOP_SUB) ? ALU_SUB : (alu_op == ALUOP_FUNCT) ? funct_ctl : ALU_ADD;
  end
endmodule

// File: rtl/rv32i_main_fsm.sv
// rv32i_main_fsm: Moore control FSM for the multicycle RV32I core.
// RV32I_FSM_ILLEGAL_TRAP_EN: unknown opcodes trap in an absorbing ILLEGAL state with illegal_op.
module rv32i_main_fsm
  import rv32i_ctrl_pkg::*;
  import alu_types_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  input  logic         cmp_ltu,
  output logic         pc_write,
  output logic         adr_src,
  output logic         mem_write,
  output logic         ir_write,
  output logic         reg_write,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic [1:0]   res_src,
  output logic [2:0]   imm_src,
  output alu_control_t alu_control,
`ifdef RV32I_FSM_ILLEGAL_TRAP_EN
  output logic         illegal_op,
`endif
  output logic [3:0]   state
);
  state_t state_q, state_d, nxt;
  logic pc_w, ir_w, reg_w, mem_w, adr;
  alu_src_a_t src_a;
  alu_src_b_t src_b;
  res_src_t res;
  imm_src_t imm;
  alu_op_t alu_op;
  function automatic state_t decode_next(input logic [6:0] o);
    case (o)
      OPC_LOAD, OPC_STORE: return S_MEMADR;
      OPC_R:      return S_EXEC_R;
      OPC_I:      return S_EXEC_I;
      OPC_BRANCH: return S_BRANCH;
      OPC_JAL:    return S_JAL;
      OPC_JALR:   return S_JALR;
      OPC_LUI:    return S_LUI;
      OPC_AUIPC:  return S_AUIPC;
`ifdef RV32I_FSM_ILLEGAL_TRAP_EN
      default:    return S_ILLEGAL;
`else
      default:    return S_FETCH;
`endif
    endcase
  endfunction
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    nxt = state_q;
    pc_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    adr = 1'b0;
    src_a = A_PC;
    src_b = B_REG_B;
    res = R_ALU_OUT;
    imm = IMM_I;
    alu_op = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        src_b = B_FOUR;
        res = R_ALU_RESULT;
        nxt = S_DECODE;
      end
      // JAL needs its J-immediate target precomputed here, everything else uses the B form
      S_DECODE: begin
        src_a = A_OLD_PC;
        src_b = B_IMM;
        imm = (op == OPC_JAL) ? IMM_J : IMM_B;
        nxt = decode_next(op);
      end
      S_MEMADR: begin
        src_a = A_REG_A;
        src_b = B_IMM;
        imm = op[5] ? IMM_S : IMM_I;
        nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        nxt = S_MEMWB;
      end
      S_MEMWB: begin
        res = R_DATA;
        reg_w = 1'b1;
        nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        mem_w = 1'b1;
        nxt = S_FETCH;
      end
      S_EXEC_R: begin
        src_a = A_REG_A;
        alu_op = ALUOP_FUNCT;
        nxt = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a = A_REG_A;
        src_b = B_IMM;
        alu_op = ALUOP_FUNCT;
        nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        src_a = A_REG_A;
        alu_op = ALUOP_SUB;
        pc_w = branch_taken(funct3, cmp_eq, cmp_lt, cmp_ltu);
        nxt = S_FETCH;
      end
      S_JAL: begin
        src_a = A_OLD_PC;
        src_b = B_FOUR;
        pc_w = 1'b1;
        nxt = S_ALUWB;
      end
      S_JALR: begin
        src_a = A_REG_A;
        src_b = B_IMM;
        res = R_ALU_RESULT;
        pc_w = 1'b1;
        nxt = S_JALWB;
      end
      S_JALWB: begin
        src_a = A_OLD_PC;
        src_b = B_FOUR;
        res = R_ALU_RESULT;
        reg_w = 1'b1;
        nxt = S_FETCH;
      end
      S_LUI: begin
        src_a = A_ZERO;
        src_b = B_IMM;
        imm = IMM_U;
        nxt = S_ALUWB;
      end
      S_AUIPC: begin
        src_a = A_OLD_PC;
        src_b = B_IMM;
        imm = IMM_U;
        nxt = S_ALUWB;
      end
      S_ILLEGAL: nxt = S_ILLEGAL;
      default: nxt = S_FETCH;
    endcase
    state_d = ena ? nxt : state_q;
  end
  rv32i_alu_decoder u_alu_dec (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .op5        (op[5]),
    .alu_control(alu_control)
  );
  assign pc_write  = pc_w & ena & ~rst;
  assign ir_write  = ir_w & ena & ~rst;
  assign reg_write = reg_w & ena & ~rst;
  assign mem_write = mem_w & ena & ~rst;
  assign adr_src   = adr;
  assign alu_src_a = src_a;
  assign alu_src_b = src_b;
  assign res_src   = res;
  assign imm_src   = imm;
  assign state     = state_q;
`ifdef RV32I_FSM_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_ILLEGAL);
`endif
endmodule
